run_controller: RTL and testbench

- Synthesizable run/reset sequencer and cycle monitor for the 4-bit CPU system.
- Holds the CPU in reset for a programmable number of clocks after a start request, then runs it for a bounded or unbounded number of cycles.
- Counts clocks and instruction cycles, and checks that the CPU sync pulse arrives on the expected 8-phase cadence.
- Sits beside the system top and drives the CPU reset. Used on FPGA boards and in regression benches in place of hand-written reset/finish sequencing.

---
 rtl/run_ctrl_pkg.sv | 5 +
 rtl/sync_phase_tracker.sv | 45 ++++
 rtl/run_controller.sv | 90 +++++++++
 tb/tb_run_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding and CPU timing constants for the run controller.
package run_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RST_HOLD, RUN, DONE} run_state_t;
    localparam int CPU_PHASES = 8;
endpackage

// File: rtl/sync_phase_tracker.sv
// sync_phase_tracker: follows the CPU instruction-cycle phase and checks sync cadence.
//   clock/reset  system clock, synchronous active-high reset
//   enable       high while the controller is in RUN; state holds otherwise
//   clear        restart request; drops lock, counts and error flag
//   sync         CPU phase-0 pulse
//   phase        current phase within the instruction cycle
//   instr_count  sync pulses seen while enabled
//   sync_error   sticky cadence violation (early or missing pulse)
module sync_phase_tracker
    import run_ctrl_pkg::*;
#(
    parameter int CYCLE_WIDTH = 32,
    parameter int PHASES      = CPU_PHASES
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic                      sync,
    output logic [$clog2(PHASES)-1:0] phase,
    output logic [CYCLE_WIDTH-1:0]    instr_count,
    output logic                      sync_error
);
    localparam int PW = $clog2(PHASES);
    logic          locked;
    logic [PW-1:0] phase_inc;
    assign phase_inc = (phase == PW'(PHASES - 1)) ? '0 : phase + 1'b1;
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            phase       <= '0;
            locked      <= 1'b0;
            instr_count <= '0;
            sync_error  <= 1'b0;
        end else if (enable) begin
            // a sync always realigns to phase 1; unlocked phase parks at 0
            phase  <= sync ? PW'(1) : (locked ? phase_inc : '0);
            locked <= locked | sync;
            if (sync)
                instr_count <= instr_count + 1'b1;
            // once locked, sync must coincide exactly with phase 0
            if (locked && (sync != (phase == '0)))
                sync_error <= 1'b1;
        end
    end
endmodule

// File: rtl/run_controller.sv
// run_controller: CPU reset/run sequencer with cycle counting and sync cadence monitor.
//   clock/reset  system clock, synchronous active-high controller reset
//   start        one-clock request to begin a reset/run sequence (IDLE or DONE only)
//   stop         early termination while in RUN
//   sync         CPU phase-0 pulse
//   cpu_reset    reset to the CPU, low only in RUN
//   running      high in RUN
//   done         high in DONE
//   cycle_count  clocks spent in RUN
//   instr_count  sync pulses seen in RUN
//   phase        current instruction-cycle phase
//   sync_error   sticky cadence violation
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int CYCLE_WIDTH  = 32,
    parameter int RESET_CYCLES = 2,
    parameter int RUN_CYCLES   = 512,
    parameter int PHASES       = CPU_PHASES
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      sync,
    output logic                      cpu_reset,
    output logic                      running,
    output logic                      done,
    output logic [CYCLE_WIDTH-1:0]    cycle_count,
    output logic [CYCLE_WIDTH-1:0]    instr_count,
    output logic [$clog2(PHASES)-1:0] phase,
    output logic                      sync_error
);
    localparam int                     HW         = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HW-1:0]          LAST_HOLD  = HW'(RESET_CYCLES - 1);
    localparam logic [CYCLE_WIDTH-1:0] LAST_CYCLE = CYCLE_WIDTH'(RUN_CYCLES - 1);
    run_state_t    state, next_state;
    logic [HW-1:0] hold_count;
    logic          clear;
    always_comb begin
        next_state = state;
        clear      = 1'b0;
        case (state)
            IDLE, DONE: begin
                clear      = start;
                next_state = start ? RST_HOLD : state;
            end
            RST_HOLD: next_state = (hold_count == LAST_HOLD) ? RUN : RST_HOLD;
            RUN: next_state = (stop || (RUN_CYCLES != 0 && cycle_count == LAST_CYCLE)) ? DONE : RUN;
            default: next_state = IDLE;
        endcase
    end
    // outputs are registered from next_state so they align with the state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            hold_count  <= '0;
            cycle_count <= '0;
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state     <= next_state;
            cpu_reset <= next_state != RUN;
            running   <= next_state == RUN;
            done      <= next_state == DONE;
            if (clear) begin
                hold_count  <= '0;
                cycle_count <= '0;
            end else if (state == RST_HOLD) begin
                hold_count <= hold_count + 1'b1;
            end else if (state == RUN) begin
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end
    sync_phase_tracker #(
        .CYCLE_WIDTH(CYCLE_WIDTH),
        .PHASES     (PHASES)
    ) u_tracker (
        .clock      (clock),
        .reset      (reset),
        .enable     (state == RUN),
        .clear      (clear),
        .sync       (sync),
        .phase      (phase),
        .instr_count(instr_count),
        .sync_error (sync_error)
    );
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed self-checking bench for run_controller.
module tb_run_controller;
    logic        clock = 1'b0;
    logic        reset = 1'b1, start = 1'b0, stop = 1'b0, sync = 1'b0;
    logic        cpu_reset, running, done, sync_error;
    logic [31:0] cycle_count, instr_count;
    logic [2:0]  phase;
    logic        b_reset = 1'b1, b_start = 1'b0, b_stop = 1'b0, b_sync = 1'b0;
    logic        b_cpu_reset, b_running, b_done, b_sync_error;
    logic [3:0]  b_cycle_count, b_instr_count;
    logic [2:0]  b_phase;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    run_controller dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .sync(sync),
        .cpu_reset(cpu_reset), .running(running), .done(done),
        .cycle_count(cycle_count), .instr_count(instr_count),
        .phase(phase), .sync_error(sync_error)
    );

    run_controller #(.CYCLE_WIDTH(4), .RUN_CYCLES(0)) dut_wrap (
        .clock(clock), .reset(b_reset), .start(b_start), .stop(b_stop), .sync(b_sync),
        .cpu_reset(b_cpu_reset), .running(b_running), .done(b_done),
        .cycle_count(b_cycle_count), .instr_count(b_instr_count),
        .phase(b_phase), .sync_error(b_sync_error)
    );

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(1));
        chk({tag, "_running"}, 64'(running), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_cycle"}, 64'(cycle_count), 64'(0));
        chk({tag, "_instr"}, 64'(instr_count), 64'(0));
        chk({tag, "_phase"}, 64'(phase), 64'(0));
        chk({tag, "_sync_error"}, 64'(sync_error), 64'(0));
    endtask

    initial begin
        // controller reset
        tick();
        tick();
        chk_reset_values("por");
        reset = 1'b0;
        tick();
        chk("idle_cpu_reset", 64'(cpu_reset), 64'(1));
        // start: two hold clocks then RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hold1_cpu_reset", 64'(cpu_reset), 64'(1));
        chk("hold1_running", 64'(running), 64'(0));
        tick();
        chk("hold2_cpu_reset", 64'(cpu_reset), 64'(1));
        chk("hold2_running", 64'(running), 64'(0));
        tick();
        chk("run0_cpu_reset", 64'(cpu_reset), 64'(0));
        chk("run0_running", 64'(running), 64'(1));
        chk("run0_cycle", 64'(cycle_count), 64'(0));
        // full default run with sync every 8 clocks; start mid-run is ignored
        for (int k = 0; k < 512; k++) begin
            sync  = (k % 8 == 0);
            start = (k == 20);
            tick();
            if (k < 8)
                chk($sformatf("cadence_phase_k%0d", k), 64'(phase), 64'((k + 1) % 8));
            if (k == 20) begin
                chk("start_in_run_running", 64'(running), 64'(1));
                chk("start_in_run_cycle", 64'(cycle_count), 64'(21));
            end
            if (k == 510) begin
                chk("pre_done_running", 64'(running), 64'(1));
                chk("pre_done_done", 64'(done), 64'(0));
            end
        end
        sync  = 1'b0;
        start = 1'b0;
        chk("done_running", 64'(running), 64'(0));
        chk("done_done", 64'(done), 64'(1));
        chk("done_cpu_reset", 64'(cpu_reset), 64'(1));
        chk("done_cycle", 64'(cycle_count), 64'(512));
        chk("done_instr", 64'(instr_count), 64'(64));
        chk("done_sync_error", 64'(sync_error), 64'(0));
        chk("done_phase", 64'(phase), 64'(0));
        tick();
        chk("done_hold_cycle", 64'(cycle_count), 64'(512));
        // restart from DONE clears everything
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_cycle", 64'(cycle_count), 64'(0));
        chk("restart_instr", 64'(instr_count), 64'(0));
        chk("restart_done", 64'(done), 64'(0));
        chk("restart_cpu_reset", 64'(cpu_reset), 64'(1));
        chk("restart_running", 64'(running), 64'(0));
        tick();
        tick();
        chk("rerun_running", 64'(running), 64'(1));
        // early sync at k=7, then 8-spaced from there; stop at k=100
        for (int k = 0; k <= 100; k++) begin
            sync = (k == 0) || (k % 8 == 7);
            stop = (k == 100);
            tick();
            if (k == 6)
                chk("early_pre_error", 64'(sync_error), 64'(0));
            if (k == 7) begin
                chk("early_error", 64'(sync_error), 64'(1));
                chk("early_phase", 64'(phase), 64'(1));
                chk("early_instr", 64'(instr_count), 64'(2));
            end
            if (k == 23) begin
                chk("realigned_phase", 64'(phase), 64'(1));
                chk("realigned_instr", 64'(instr_count), 64'(4));
            end
        end
        sync = 1'b0;
        stop = 1'b0;
        chk("stop_done", 64'(done), 64'(1));
        chk("stop_running", 64'(running), 64'(0));
        chk("stop_cpu_reset", 64'(cpu_reset), 64'(1));
        chk("stop_cycle", 64'(cycle_count), 64'(101));
        chk("stop_instr", 64'(instr_count), 64'(13));
        chk("stop_phase", 64'(phase), 64'(6));
        chk("stop_sync_error", 64'(sync_error), 64'(1));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_in_done_cycle", 64'(cycle_count), 64'(101));
        chk("stop_in_done_done", 64'(done), 64'(1));
        // restart, miss the second pulse, then reset mid-run
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 50; k++) begin
            sync = (k == 0);
            tick();
            if (k == 8) begin
                chk("missing_error", 64'(sync_error), 64'(1));
                chk("missing_phase", 64'(phase), 64'(1));
                chk("missing_instr", 64'(instr_count), 64'(1));
            end
        end
        sync = 1'b0;
        chk("prereset_cycle", 64'(cycle_count), 64'(50));
        chk("prereset_running", 64'(running), 64'(1));
        reset = 1'b1;
        tick();
        chk_reset_values("midrun");
        reset = 1'b0;
        tick();
        chk("post_reset_idle_running", 64'(running), 64'(0));
        // unbounded run with 4-bit counter wraps and waits for stop
        b_reset = 1'b0;
        tick();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        tick();
        tick();
        chk("wrap_run0_running", 64'(b_running), 64'(1));
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 14)
                chk("wrap_cycle15", 64'(b_cycle_count), 64'(15));
            if (k == 15)
                chk("wrap_cycle0", 64'(b_cycle_count), 64'(0));
            if (k == 20)
                chk("wrap_still_running", 64'(b_running), 64'(1));
        end
        chk("wrap_running_k40", 64'(b_running), 64'(1));
        chk("wrap_done_k40", 64'(b_done), 64'(0));
        b_stop = 1'b1;
        tick();
        b_stop = 1'b0;
        chk("wrap_stop_running", 64'(b_running), 64'(0));
        chk("wrap_stop_done", 64'(b_done), 64'(1));
        chk("wrap_stop_cycle", 64'(b_cycle_count), 64'(9));
        chk("wrap_stop_cpu_reset", 64'(b_cpu_reset), 64'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
